// File: rtl/io_ctrl_if.sv
// io_ctrl CPU data-bus interface.
// Master drives the bus; slave (io_ctrl) returns combinational read data.
interface io_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_i;
  logic [31:0]       data_o;

  modport master (
    output ce,
    output we,
    output addr,
    output data_i,
    input  data_o
  );

  modport slave (
    input  ce,
    input  we,
    input  addr,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped LED/SEG/switch/button controller with irq.
// Optional macro IO_DEBOUNCE_EN adds per-bit debounce counters.
module io_ctrl #(
  parameter int SW_W       = 16,
  parameter int BTN_W      = 4,
  parameter int LED_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int ADDR_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  io_ctrl_if.slave         bus,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic [31:0]      seg,
  output logic             irq
);

  localparam int IN_W = SW_W + BTN_W;

  // Register offsets decoded from addr[4:2]
  localparam logic [2:0] OFF_LED   = 3'd0;
  localparam logic [2:0] OFF_SEG   = 3'd1;
  localparam logic [2:0] OFF_SW    = 3'd2;
  localparam logic [2:0] OFF_BTN   = 3'd3;
  localparam logic [2:0] OFF_EDGE  = 3'd4;
  localparam logic [2:0] OFF_IMASK = 3'd5;

  logic [2:0]      off;
  logic            wr_en;
  logic            rd_en;
  logic [5:0]      sel;

  logic [IN_W-1:0] raw;
  logic [IN_W-1:0] s1_d, s1_q;
  logic [IN_W-1:0] s2_d, s2_q;
  logic [IN_W-1:0] deb;

  logic [SW_W-1:0]  sw_deb;
  logic [BTN_W-1:0] btn_deb;
  logic [BTN_W-1:0] btn_dly_d, btn_dly_q;
  logic [BTN_W-1:0] rise;
  logic [BTN_W-1:0] clr;

  logic [LED_W-1:0] led_d, led_q;
  logic [31:0]      seg_d, seg_q;
  logic [BTN_W-1:0] edge_d, edge_q;
  logic [BTN_W-1:0] imask_d, imask_q;
  logic             irq_d, irq_q;

  logic             unused_ok;

  assign off   = bus.addr[4:2];
  assign wr_en = bus.ce & bus.we;
  assign rd_en = bus.ce & ~bus.we;
  assign raw   = {btn, sw};

  assign unused_ok = ^{bus.addr[ADDR_W-1:5], bus.addr[1:0]};

  // One-hot register select
  always_comb begin
    sel = '0;
    sel[0] = (off == OFF_LED);
    sel[1] = (off == OFF_SEG);
    sel[2] = (off == OFF_SW);
    sel[3] = (off == OFF_BTN);
    sel[4] = (off == OFF_EDGE);
    sel[5] = (off == OFF_IMASK);
  end

  // Two-flop synchroniser next state
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [IN_W-1:0] deb_d, deb_q;
  logic [CW-1:0]   cnt_d [IN_W];
  logic [CW-1:0]   cnt_q [IN_W];

  // Per-bit debounce: count consecutive disagreeing cycles
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < IN_W; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state flops
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < IN_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < IN_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign deb = deb_q;
`else
  localparam int unused_deb = DEB_CYCLES;

  assign deb = s2_q;
`endif

  assign sw_deb  = deb[SW_W-1:0];
  assign btn_deb = deb[IN_W-1:SW_W];
  assign rise    = btn_deb & ~btn_dly_q;

  // Register writes, W1C edge status, irq
  always_comb begin
    led_d     = led_q;
    seg_d     = seg_q;
    imask_d   = imask_q;
    clr       = '0;
    btn_dly_d = btn_deb;
    if (wr_en) begin
      unique case (1'b1)
        sel[0]:  led_d   = bus.data_i[LED_W-1:0];
        sel[1]:  seg_d   = bus.data_i;
        sel[4]:  clr     = bus.data_i[BTN_W-1:0];
        sel[5]:  imask_d = bus.data_i[BTN_W-1:0];
        default: ;
      endcase
    end
    edge_d = (edge_q & ~clr) | rise;
    irq_d  = |(edge_q & imask_q);
  end

  // Register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      seg_q     <= '0;
      edge_q    <= '0;
      imask_q   <= '0;
      irq_q     <= 1'b0;
      btn_dly_q <= '0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      edge_q    <= edge_d;
      imask_q   <= imask_d;
      irq_q     <= irq_d;
      btn_dly_q <= btn_dly_d;
    end
  end

  // Combinational read mux, zero-extended
  always_comb begin
    bus.data_o = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel[0]:  bus.data_o = 32'(led_q);
        sel[1]:  bus.data_o = seg_q;
        sel[2]:  bus.data_o = 32'(sw_deb);
        sel[3]:  bus.data_o = 32'(btn_deb);
        sel[4]:  bus.data_o = 32'(edge_q);
        sel[5]:  bus.data_o = 32'(imask_q);
        default: bus.data_o = '0;
      endcase
    end
  end

  assign led = led_q;
  assign seg = seg_q;
  assign irq = irq_q;

endmodule
